// File: rtl/magic_packet_driver.sv
// magic_packet_driver
// Drives a legal push/pop/data stream into a DEPTH-entry FIFO, injects one
// tracked "magic" packet (flagged by a one-cycle start pulse), then drains
// the FIFO.  A shadow occupancy counter gates the requests so the FIFO can
// never overflow or underflow.
module magic_packet_driver #(
   parameter int          DEPTH     = 8,
   parameter int          WIDTH     = 8,
   parameter int          CNTWID    = $clog2(DEPTH) + 1,
   parameter int          INJECT_AT = 3,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              push_req,
   input  logic              pop_req,
   output logic              push,
   output logic              pop,
   output logic              start,
   output logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  magic,
   output logic [CNTWID-1:0] cnt,
   output logic              done
);

   // pushes only has to reach INJECT_AT; it is cleared on the magic push
   localparam int PWID = $clog2(INJECT_AT + 1) + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_TRACK,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [CNTWID-1:0] cnt_reg, cnt_next;
   logic [CNTWID-1:0] ahead_reg, ahead_next;
   logic [PWID-1:0]   pushes_reg, pushes_next;
   logic [WIDTH-1:0]  magic_reg;
   logic [15:0]       lfsr_reg;
   logic              push_ok;
   logic              pop_ok;

   // 16-bit Galois LFSR, taps 16,14,13,11
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Conservative gating: full blocks push even with a simultaneous pop,
   // empty blocks pop even with a simultaneous push.
   assign push_ok = push_req && (cnt_reg < CNTWID'(DEPTH));
   assign pop_ok  = pop_req && (cnt_reg != '0);

   assign data_in = lfsr_reg[WIDTH-1:0];
   assign magic   = magic_reg;
   assign cnt     = cnt_reg;

   // Next-state and output decode; outputs depend on state, registers and reqs
   always_comb begin
      state_next  = state_reg;
      ahead_next  = ahead_reg;
      pushes_next = pushes_reg;
      push        = 1'b0;
      pop         = 1'b0;
      start       = 1'b0;
      done        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (go) state_next = ST_FILL;
         end
         ST_FILL: begin
            push = push_ok;
            pop  = pop_ok;
            if (push_ok) begin
               if (pushes_reg == PWID'(INJECT_AT)) begin
                  // Magic push: remember how many entries sit in front of it
                  start       = 1'b1;
                  ahead_next  = cnt_reg - CNTWID'(pop_ok);
                  pushes_next = '0;
                  state_next  = ST_TRACK;
               end else begin
                  pushes_next = pushes_reg + PWID'(1);
               end
            end
         end
         ST_TRACK: begin
            push = push_ok;
            pop  = pop_ok;
            if (pop_ok) begin
               if (ahead_reg == '0) state_next = ST_DRAIN;
               else                 ahead_next = ahead_reg - CNTWID'(1);
            end
         end
         ST_DRAIN: begin
            pop = pop_ok;
            // Leave as soon as the FIFO is (or is about to become) empty, so
            // done rises on the cycle right after the last pop.
            if (cnt_reg == CNTWID'(pop_ok)) state_next = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (go) state_next = ST_FILL;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Shadow occupancy: simultaneous push and pop cancel out
   always_comb begin
      cnt_next = cnt_reg;
      if (push && !pop)      cnt_next = cnt_reg + CNTWID'(1);
      else if (pop && !push) cnt_next = cnt_reg - CNTWID'(1);
   end

   // State registers; reset aborts any run immediately
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         ahead_reg  <= '0;
         pushes_reg <= '0;
         magic_reg  <= '0;
         lfsr_reg   <= SEED;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ahead_reg  <= ahead_next;
         pushes_reg <= pushes_next;
         if (start) magic_reg <= lfsr_reg[WIDTH-1:0];
         if (push)  lfsr_reg  <= lfsr_step(lfsr_reg);
      end
   end

endmodule

// File: tb/tb_magic_packet_driver.sv
// tb_magic_packet_driver
// Directed checks of a default-parameter driver (INJECT_AT=3) and a second
// instance with INJECT_AT=0, followed by a random request stream that must
// keep the occupancy inside 0..DEPTH.
module tb_magic_packet_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       go = 1'b0, push_req = 1'b0, pop_req = 1'b0;
   logic       go0 = 1'b0, push_req0 = 1'b0, pop_req0 = 1'b0;
   logic       push, pop, start, done;
   logic       push0, pop0, start0, done0;
   logic [7:0] data_in, magic, data_in0, magic0;
   logic [3:0] cnt, cnt0;
   logic       rpr, rqr;

   int vectors     = 0;
   int miscompares = 0;

   // Expected data of the first two runs: LFSR sequence from 16'hACE1
   logic [7:0] run1_data [8] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89};
   logic [7:0] run2_data [8] = '{8'hC4, 8'h62, 8'hB1, 8'h58, 8'h2C, 8'h16, 8'h8B, 8'hC5};

   magic_packet_driver dut (
      .clk(clk), .rst(rst), .go(go), .push_req(push_req), .pop_req(pop_req),
      .push(push), .pop(pop), .start(start), .data_in(data_in), .magic(magic),
      .cnt(cnt), .done(done)
   );

   magic_packet_driver #(.INJECT_AT(0)) dut0 (
      .clk(clk), .rst(rst), .go(go0), .push_req(push_req0), .pop_req(pop_req0),
      .push(push0), .pop(pop0), .start(start0), .data_in(data_in0), .magic(magic0),
      .cnt(cnt0), .done(done0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs after the falling edge, settle, then return
   task automatic cyc(input logic r, input logic g, input logic pr, input logic qr,
                      input logic g0, input logic pr0, input logic qr0);
      @(negedge clk);
      rst = r; go = g; push_req = pr; pop_req = qr;
      go0 = g0; push_req0 = pr0; pop_req0 = qr0;
      #1;
   endtask

   initial begin
      // Reset held two cycles, then idle with go=0
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         chk("idle_ctrl", {push, pop, start, done}, 4'b0000);
         chk("idle_cnt", cnt, 0);
         chk("idle_data", data_in, 8'hE1);
      end

      // Run 1 fill: go pulse, then continuous push requests
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("go_cycle_push", push, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 1, 0, 0, 0, 0);
         chk("fill_push", push, 1);
         chk("fill_data", data_in, run1_data[i]);
         chk("fill_start", start, (i == 3));
         chk("fill_cnt", cnt, 16'(i));
         if (i == 4) chk("fill_magic", magic, 8'h9C);
      end
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("full_push", push, 0);
      chk("full_cnt", cnt, 8);
      chk("full_data", data_in, 8'hC4);

      // Run 1 drain: magic leaves on the 4th pop; afterwards push is locked out
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, (i >= 4), 1, 0, 0, 0);
         chk("drain_pop", pop, 1);
         chk("drain_push", push, 0);
         chk("drain_cnt", cnt, 16'(8 - i));
         chk("drain_done", done, 0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("done_flag", done, 1);
      chk("done_cnt", cnt, 0);
      chk("done_magic", magic, 8'h9C);

      // Run 2: empty with both reqs -> push only; LFSR continues from run 1
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("rerun_done", done, 1);
      cyc(1, 0, 1, 1, 0, 0, 0);
      chk("empty_both_push", push, 1);
      chk("empty_both_pop", pop, 0);
      chk("empty_both_data", data_in, run2_data[0]);
      for (int i = 1; i < 8; i++) begin
         cyc(1, 0, 1, 0, 0, 0, 0);
         chk("run2_push", push, 1);
         chk("run2_data", data_in, run2_data[i]);
         chk("run2_start", start, (i == 3));
         chk("run2_cnt", cnt, 16'(i));
      end
      // Full with both reqs -> pop only
      cyc(1, 0, 1, 1, 0, 0, 0);
      chk("full_both_push", push, 0);
      chk("full_both_pop", pop, 1);
      chk("full_both_magic", magic, 8'h58);
      cyc(1, 0, 0, 1, 0, 0, 0);
      chk("full_both_cnt", cnt, 7);
      cyc(1, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("track_cnt5", cnt, 5);
      chk("track_done", done, 0);

      // Reset in TRACK with cnt=5 aborts the run
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      chk("abort_cnt", cnt, 0);
      chk("abort_magic", magic, 0);
      chk("abort_ctrl", {push, pop, start, done}, 4'b0000);
      chk("abort_data", data_in, 8'hE1);

      // INJECT_AT=0 instance: first push is magic, next pop ends tracking
      cyc(1, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      chk("ia0_push", push0, 1);
      chk("ia0_start", start0, 1);
      chk("ia0_data", data_in0, 8'hE1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("ia0_pop", pop0, 1);
      chk("ia0_magic", magic0, 8'hE1);
      cyc(1, 0, 0, 0, 0, 1, 1);
      chk("ia0_drain_ctrl", {push0, pop0, done0}, 3'b000);
      chk("ia0_drain_cnt", cnt0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("ia0_done", done0, 1);

      // Random requests: occupancy and gating must stay legal
      cyc(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         if (i < 150) rpr = ($urandom_range(0, 3) != 0);
         else         rpr = ($urandom_range(0, 3) == 0);
         rqr = ($urandom_range(0, 1) != 0);
         cyc(1, done, rpr, rqr, 0, 0, 0);
         chk("rand_cnt_range", (cnt <= 4'd8), 1);
         chk("rand_push_gate", (push && cnt == 4'd8), 0);
         chk("rand_pop_gate", (pop && cnt == 4'd0), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
